mbist_march_ctrl: RTL

- Memory BIST initiator that runs a March C- sequence on the `write_read`/`address`/`wdata`/`rdata` memory port used by the fault memory models.
- Generates addresses, data backgrounds and read/write strobes.
- Compares read data through a pipeline matched to the memory's latency.
- Reports pass/fail, the first failing address and a saturating mismatch count.

---
 rtl/mbist_pkg.sv | 55 +++++
 rtl/mbist_march_ctrl_if.sv | 27 ++
 rtl/mbist_march_ctrl_cmp.sv | 82 ++++++++
 rtl/mbist_march_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mbist_pkg.sv
// mbist_pkg: controller state encoding, March C- element table
// and the data-background generator shared by the BIST blocks.
package mbist_pkg;

  localparam int MAX_DW = 64;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRIME,
    S_M0,
    S_M1,
    S_M2,
    S_M3,
    S_M4,
    S_M5,
    S_DRAIN,
    S_DONE
  } state_e;

  // Element table: one bit per state code (bit n = state value n).
  // PAIR marks two-op (r,w) elements; DOWN marks descending order.
  localparam logic [9:0] EL_DOWN = 10'b00_0110_0000;
  localparam logic [9:0] EL_PAIR = 10'b00_0111_1000;
  localparam logic [9:0] EL_RD   = 10'b00_1111_1000;
  localparam logic [9:0] EL_WR   = 10'b00_0111_1100;
  localparam logic [9:0] EL_RPOL = 10'b00_0101_0000;
  localparam logic [9:0] EL_WPOL = 10'b00_0010_1000;

  function automatic state_e next_elem(state_e s);
    state_e n;
    case (s)
      S_M0:    n = S_M1;
      S_M1:    n = S_M2;
      S_M2:    n = S_M3;
      S_M3:    n = S_M4;
      S_M4:    n = S_M5;
      default: n = S_DRAIN;
    endcase
    return n;
  endfunction

  function automatic logic [MAX_DW-1:0] pat(
    logic odd,
    logic bg,
    logic inv
  );
    logic [MAX_DW-1:0] p;
    p = '0;
    if (bg)
      p = odd ? {(MAX_DW/2){2'b10}}
              : {(MAX_DW/2){2'b01}};
    return inv ? ~p : p;
  endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// mbist_march_ctrl_if: memory-side port of the BIST controller
// (write_read/address/wdata out, rdata back from the memory).
interface mbist_march_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);

  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output write_read,
    output address,
    output wdata,
    input  rdata
  );

  modport slave (
    input  write_read,
    input  address,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/mbist_march_ctrl_cmp.sv
// mbist_cmp: read-compare pipeline aligned to the 2-cycle memory
// latency, with sticky pass, first-fail address and saturating count.
module mbist_cmp #(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          rd_i,
  input  logic [DW-1:0] exp_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] rdata_i,
  output logic          pass_o,
  output logic [AW-1:0] fail_addr_o,
  output logic [CW-1:0] fail_count_o
);

  logic          v1_q, v2_q;
  logic [DW-1:0] e1_q, e2_q;
  logic [AW-1:0] a1_q, a2_q;
  logic          pass_q, pass_d;
  logic [AW-1:0] fa_q, fa_d;
  logic [CW-1:0] fc_q, fc_d;
  logic          miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      e1_q <= '0;
      e2_q <= '0;
      a1_q <= '0;
      a2_q <= '0;
    end else begin
      v1_q <= rd_i;
      v2_q <= v1_q;
      e1_q <= exp_i;
      e2_q <= e1_q;
      a1_q <= addr_i;
      a2_q <= a1_q;
    end
  end

  assign miss = v2_q && (rdata_i != e2_q);

  // pass_q doubles as "no mismatch seen yet" for the first-fail latch
  always_comb begin
    pass_d = pass_q;
    fa_d   = fa_q;
    fc_d   = fc_q;
    if (clr_i) begin
      pass_d = 1'b1;
      fa_d   = '0;
      fc_d   = '0;
    end else if (miss) begin
      pass_d = 1'b0;
      if (pass_q)
        fa_d = a2_q;
      if (fc_q != '1)
        fc_d = fc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= 1'b0;
      fa_q   <= '0;
      fc_q   <= '0;
    end else begin
      pass_q <= pass_d;
      fa_q   <= fa_d;
      fc_q   <= fc_d;
    end
  end

  assign pass_o       = pass_q;
  assign fail_addr_o  = fa_q;
  assign fail_count_o = fc_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- BIST initiator driving a 2-cycle-latency
// memory port; all memory and status outputs are registered.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LAST_ADDR  = 2**ADDR_WIDTH-1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  bg_sel,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [CNT_WIDTH-1:0]  fail_count,
  mbist_march_ctrl_if.master    mem
);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(LAST_ADDR);

  state_e                st_q, st_d, nx;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ph_q, ph_d;
  logic                  bg_q, bg_d;
  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic                  at_end;
  logic                  idle_start;

  assign idle_start = start && (st_q == S_IDLE);

  // ph_q: second op of an (r,w) pair, or second DRAIN cycle
  always_comb begin
    st_d   = st_q;
    addr_d = addr_q;
    ph_d   = ph_q;
    bg_d   = bg_q;
    nx     = next_elem(st_q);
    at_end = EL_DOWN[st_q] ? (addr_q == '0)
                           : (addr_q == LAST);
    unique case (st_q)
      S_IDLE: begin
        if (start) begin
          st_d   = S_PRIME;
          addr_d = '0;
          ph_d   = 1'b0;
          bg_d   = bg_sel;
        end
      end
      S_PRIME: begin
        st_d   = S_M0;
        addr_d = '0;
        ph_d   = 1'b0;
      end
      S_DRAIN: begin
        ph_d = ~ph_q;
        if (ph_q)
          st_d = S_DONE;
      end
      S_DONE: begin
        st_d = S_IDLE;
      end
      default: begin
        if (EL_PAIR[st_q] && !ph_q) begin
          ph_d = 1'b1;
        end else begin
          ph_d = 1'b0;
          if (at_end) begin
            st_d = nx;
            if (nx != S_DRAIN)
              addr_d = EL_DOWN[nx] ? LAST : '0;
          end else if (EL_DOWN[st_q]) begin
            addr_d = addr_q - 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
    endcase
  end

  // wdata looks one op ahead: the memory commits the previous cycle's wdata
  always_comb begin
    wr_d   = EL_PAIR[st_d] ? ph_d : EL_WR[st_d];
    rd_d   = EL_PAIR[st_d] ? !ph_d : EL_RD[st_d];
    wd_d   = wd_q;
    exp_d  = DATA_WIDTH'(pat(addr_d[0], bg_d, EL_RPOL[st_d]));
    busy_d = (st_d != S_IDLE) && (st_d != S_DONE);
    done_d = (st_d == S_DONE);
    if (st_d == S_PRIME)
      wd_d = DATA_WIDTH'(pat(1'b0, bg_d, 1'b0));
    else if (wr_d && !EL_PAIR[st_d])
      wd_d = DATA_WIDTH'(pat(~addr_d[0], bg_d, EL_WPOL[st_d]));
    else if (rd_d && EL_PAIR[st_d])
      wd_d = DATA_WIDTH'(pat(addr_d[0], bg_d, EL_WPOL[st_d]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      addr_q <= '0;
      ph_q   <= 1'b0;
      bg_q   <= 1'b0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wd_q   <= '0;
      exp_q  <= '0;
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
      ph_q   <= ph_d;
      bg_q   <= bg_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      busy_q <= busy_d;
      done_q <= done_d;
      wd_q   <= wd_d;
      exp_q  <= exp_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign mem.write_read = wr_q;
  assign mem.address    = addr_q;
  assign mem.wdata      = wd_q;

  mbist_cmp #(
    .DW (DATA_WIDTH),
    .AW (ADDR_WIDTH),
    .CW (CNT_WIDTH)
  ) u_cmp (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (idle_start),
    .rd_i         (rd_q),
    .exp_i        (exp_q),
    .addr_i       (addr_q),
    .rdata_i      (mem.rdata),
    .pass_o       (pass),
    .fail_addr_o  (fail_addr),
    .fail_count_o (fail_count)
  );

endmodule
